f1_reaction_ctrl: RTL
=====================

F1_REACTION_CTRL -- requirements
Module: f1_reaction_ctrl

Interface
REQ-001 Parameter N_LIGHTS, default 5: number of start lights, range 1..16.
REQ-002 Parameter STEP_MS, default 500: ms between successive lights turning on, range 1..65535.
REQ-003 Parameter LFSR_W, default 14: random-delay LFSR width, range 4..16.
REQ-004 Parameter TIME_W, default 14: reaction-time counter width.
REQ-005 clk  in  1: single system clock.
REQ-006 rst  in  1: asynchronous, active-high reset.
REQ-007 tick_ms  in  1: one-clk-wide strobe, once per millisecond.
REQ-008 trigger  in  1: player button, level, already synchronised and debounced, 1 = pressed.
REQ-009 lights  out  N_LIGHTS: start-light drive, bit 0 lit first.
REQ-010 react_ms  out  TIME_W: last measured reaction time in ms.
REQ-011 valid  out  1: react_ms holds a fresh result.
REQ-012 jump_start  out  1: player pressed before lights went out.
REQ-013 busy  out  1: a start sequence is in progress (COUNT, HOLD or TIMING).
REQ-014 best_ms  out  TIME_W: best (smallest) valid time; present only with F1_BEST_TIME_EN.

Function
REQ-015 press = trigger rising edge, from a registered copy of trigger; press is the only event that advances IDLE, DONE, FAULT or TIMING.
REQ-016 States: IDLE, COUNT, HOLD, TIMING, DONE, FAULT.
REQ-017 IDLE: lights=0; LFSR advances one step per tick_ms; press -> COUNT, step counter and lights cleared.
REQ-018 COUNT: step counter +1 per tick_ms; on reaching STEP_MS it clears and the next light (lowest unlit bit) turns on in the same cycle.
REQ-019 COUNT -> HOLD in the cycle all N_LIGHTS are lit; delay counter loaded with current LFSR value (never 0).
REQ-020 HOLD: delay counter -1 per tick_ms; on reaching 0 lights=0, reaction counter cleared -> TIMING.
REQ-021 TIMING: reaction counter +1 per tick_ms, saturating at all-ones; press -> DONE, react_ms <= counter, valid=1.
REQ-022 press in COUNT or HOLD -> FAULT, jump_start=1, lights frozen at current pattern, react_ms unchanged.
REQ-023 press coincident with HOLD expiry counts as jump start (FAULT wins).
REQ-024 press in the cycle TIMING is entered is legal; react_ms=0.
REQ-025 DONE/FAULT: outputs held; press -> COUNT directly (new sequence), clearing valid and jump_start.
REQ-026 LFSR: maximal-length Fibonacci, seed 1, zero state unreachable.

Reset
REQ-027 On rst: state IDLE, lights=0, react_ms=0, valid=0, jump_start=0, busy=0, best_ms=all-ones, LFSR=1, all counters 0; effective immediately, including mid-sequence.

Configuration
REQ-028 F1_BEST_TIME_EN defined: best_ms port exists; on each DONE entry best_ms <= min(best_ms, new react_ms); cleared only by rst.
REQ-029 F1_BEST_TIME_EN undefined: best_ms port and its register absent; all other behaviour identical.

Structure
REQ-030 Package f1_pkg holds the state enum type and LFSR tap constants per LFSR_W.
REQ-031 Sub-module lfsr_n (parameter WIDTH, ports clk, rst, en, prbs) provides the random source.

Verification (N_LIGHTS=5, STEP_MS=2, LFSR_W=4, tick_ms every 4 clk)
REQ-032 rst pulse mid-HOLD -> next cycle state IDLE, lights=0, busy=0, LFSR=1.
REQ-033 press from IDLE -> lights 00001,00011,...,11111 each after 2 ticks; HOLD entered with busy=1.
REQ-034 No press until lights out, press after 37 ticks -> valid=1, react_ms=37, jump_start=0.
REQ-035 press while lights=00111 -> FAULT, jump_start=1, lights stay 00111; next press restarts at 00001 with flags cleared.
REQ-036 Hold trigger in TIMING for 2^14 ticks with TIME_W=14 -> react_ms saturates at 16383.
REQ-037 F1_BEST_TIME_EN: runs of 200, 150, 300 ms -> best_ms 200, 150, 150.

Source files
------------

// File: rtl/f1_reaction_ctrl_pkg.sv
// Shared types for the F1 reaction-time controller: FSM state encoding and
// maximal-length LFSR tap masks, where bit k-1 set means tap k.
package f1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COUNT  = 3'd1,
    ST_HOLD   = 3'd2,
    ST_TIMING = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } f1_state_e;

  localparam logic [15:0] TAPS_W4  = 16'h000C;
  localparam logic [15:0] TAPS_W5  = 16'h0014;
  localparam logic [15:0] TAPS_W6  = 16'h0030;
  localparam logic [15:0] TAPS_W7  = 16'h0060;
  localparam logic [15:0] TAPS_W8  = 16'h00B8;
  localparam logic [15:0] TAPS_W9  = 16'h0110;
  localparam logic [15:0] TAPS_W10 = 16'h0240;
  localparam logic [15:0] TAPS_W11 = 16'h0500;
  localparam logic [15:0] TAPS_W12 = 16'h0829;
  localparam logic [15:0] TAPS_W13 = 16'h100D;
  localparam logic [15:0] TAPS_W14 = 16'h2015;
  localparam logic [15:0] TAPS_W15 = 16'h6000;
  localparam logic [15:0] TAPS_W16 = 16'hD008;

  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      4:       return TAPS_W4;
      5:       return TAPS_W5;
      6:       return TAPS_W6;
      7:       return TAPS_W7;
      8:       return TAPS_W8;
      9:       return TAPS_W9;
      10:      return TAPS_W10;
      11:      return TAPS_W11;
      12:      return TAPS_W12;
      13:      return TAPS_W13;
      14:      return TAPS_W14;
      15:      return TAPS_W15;
      default: return TAPS_W16;
    endcase
  endfunction

endpackage

// File: rtl/f1_reaction_ctrl_if.sv
// Player/light-side signal bundle of the reaction controller.
// best_ms exists only when F1_BEST_TIME_EN is defined.
interface f1_reaction_ctrl_if #(
  parameter int N_LIGHTS = 5,
  parameter int TIME_W   = 14
);
  logic                tick_ms;
  logic                trigger;
  logic [N_LIGHTS-1:0] lights;
  logic [TIME_W-1:0]   react_ms;
  logic                valid;
  logic                jump_start;
  logic                busy;
`ifdef F1_BEST_TIME_EN
  logic [TIME_W-1:0]   best_ms;

  modport master (output tick_ms, trigger,
                  input  lights, react_ms, valid, jump_start, busy, best_ms);
  modport slave  (input  tick_ms, trigger,
                  output lights, react_ms, valid, jump_start, busy, best_ms);
`else
  modport master (output tick_ms, trigger,
                  input  lights, react_ms, valid, jump_start, busy);
  modport slave  (input  tick_ms, trigger,
                  output lights, react_ms, valid, jump_start, busy);
`endif
endinterface

// File: rtl/f1_reaction_ctrl_lfsr.sv
// Fibonacci LFSR (shift left, feedback into bit 0), seeded with 1 so the
// all-zero lock-up state is never reached.
module lfsr_n
  import f1_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] prbs
);

  localparam logic [15:0] TAPS16 = lfsr_taps(WIDTH);

  logic [WIDTH-1:0] prbs_q, prbs_d;

  always_comb begin
    prbs_d = prbs_q;
    if (en) prbs_d = {prbs_q[WIDTH-2:0], ^(prbs_q & TAPS16[WIDTH-1:0])};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prbs_q <= WIDTH'(1);
    else     prbs_q <= prbs_d;
  end

  assign prbs = prbs_q;

endmodule

// File: rtl/f1_reaction_ctrl.sv
// F1 start-light reaction timer: lights come on one per STEP_MS, go out after
// a random LFSR delay, then the press latency is measured. Best-time tracking
// is compiled in with F1_BEST_TIME_EN.
module f1_reaction_ctrl
  import f1_pkg::*;
#(
  parameter int N_LIGHTS = 5,
  parameter int STEP_MS  = 500,
  parameter int LFSR_W   = 14,
  parameter int TIME_W   = 14
) (
  input  logic               clk,
  input  logic               rst,
  f1_reaction_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_COUNT  = ST_COUNT;
  localparam logic [2:0] S_HOLD   = ST_HOLD;
  localparam logic [2:0] S_TIMING = ST_TIMING;
  localparam logic [2:0] S_DONE   = ST_DONE;
  localparam logic [2:0] S_FAULT  = ST_FAULT;

  logic [2:0]          state_q, state_d;
  logic                trig_q;
  logic [15:0]         step_q, step_d;
  logic [LFSR_W-1:0]   delay_q, delay_d;
  logic [TIME_W-1:0]   cnt_q, cnt_d;
  logic [N_LIGHTS-1:0] lights_q, lights_d;
  logic [TIME_W-1:0]   react_q, react_d;
  logic                valid_q, valid_d;
  logic                jump_q, jump_d;
  logic [LFSR_W-1:0]   lfsr_val;
  logic [N_LIGHTS-1:0] lit_next;
  logic                press;
`ifdef F1_BEST_TIME_EN
  logic [TIME_W-1:0]   best_q, best_d;
`endif

  lfsr_n #(.WIDTH(LFSR_W)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   ((state_q == S_IDLE) & bus.tick_ms),
    .prbs (lfsr_val)
  );

  assign press    = bus.trigger & ~trig_q;
  // x | (x+1) sets the lowest clear bit
  assign lit_next = lights_q | (lights_q + N_LIGHTS'(1));

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    delay_d  = delay_q;
    cnt_d    = cnt_q;
    lights_d = lights_q;
    react_d  = react_q;
    valid_d  = valid_q;
    jump_d   = jump_q;
`ifdef F1_BEST_TIME_EN
    best_d   = best_q;
`endif
    case (state_q)
      S_IDLE: begin
        lights_d = '0;
        if (press) begin
          state_d = S_COUNT;
          step_d  = '0;
        end
      end
      S_COUNT: begin
        if (press) begin
          state_d = S_FAULT;
          jump_d  = 1'b1;
        end else if (bus.tick_ms) begin
          if (step_q == 16'(STEP_MS - 1)) begin
            step_d   = '0;
            lights_d = lit_next;
            if (&lit_next) begin
              state_d = S_HOLD;
              delay_d = lfsr_val;
            end
          end else begin
            step_d = step_q + 16'd1;
          end
        end
      end
      S_HOLD: begin
        // a press on the expiry tick still counts as a jump start
        if (press) begin
          state_d = S_FAULT;
          jump_d  = 1'b1;
        end else if (bus.tick_ms) begin
          if (delay_q == LFSR_W'(1)) begin
            state_d  = S_TIMING;
            lights_d = '0;
            cnt_d    = '0;
          end else begin
            delay_d = delay_q - LFSR_W'(1);
          end
        end
      end
      S_TIMING: begin
        if (press) begin
          state_d = S_DONE;
          react_d = cnt_q;
          valid_d = 1'b1;
`ifdef F1_BEST_TIME_EN
          if (cnt_q < best_q) best_d = cnt_q;
`endif
        end else if (bus.tick_ms && !(&cnt_q)) begin
          cnt_d = cnt_q + TIME_W'(1);
        end
      end
      S_DONE, S_FAULT: begin
        if (press) begin
          state_d  = S_COUNT;
          step_d   = '0;
          lights_d = '0;
          valid_d  = 1'b0;
          jump_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      trig_q   <= 1'b0;
      step_q   <= '0;
      delay_q  <= '0;
      cnt_q    <= '0;
      lights_q <= '0;
      react_q  <= '0;
      valid_q  <= 1'b0;
      jump_q   <= 1'b0;
`ifdef F1_BEST_TIME_EN
      best_q   <= '1;
`endif
    end else begin
      state_q  <= state_d;
      trig_q   <= bus.trigger;
      step_q   <= step_d;
      delay_q  <= delay_d;
      cnt_q    <= cnt_d;
      lights_q <= lights_d;
      react_q  <= react_d;
      valid_q  <= valid_d;
      jump_q   <= jump_d;
`ifdef F1_BEST_TIME_EN
      best_q   <= best_d;
`endif
    end
  end

  assign bus.lights     = lights_q;
  assign bus.react_ms   = react_q;
  assign bus.valid      = valid_q;
  assign bus.jump_start = jump_q;
  assign bus.busy       = (state_q == S_COUNT) || (state_q == S_HOLD) ||
                          (state_q == S_TIMING);
`ifdef F1_BEST_TIME_EN
  assign bus.best_ms    = best_q;
`endif

endmodule
